mp_add_seq: RTL and testbench
=============================

MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of the internal adder slice.
REQ-002 SHALL have parameter WORDS, default 4: slices per operand, legal range 2..16; operand width N = WIDTH*WORDS.
REQ-003 SHALL have port Clk_i, input, 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port Reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port Start_i, input, 1: request to begin one N-bit operation.
REQ-006 SHALL have port Ready_o, output, 1: high when Start_i will be accepted.
REQ-007 SHALL have port Number1_i, input, N: operand A, sampled on accept.
REQ-008 SHALL have port Number2_i, input, N: operand B, sampled on accept.
REQ-009 SHALL have port Carry_i, input, 1: carry into slice 0, sampled on accept.
REQ-010 SHALL have port Sub_i, input, 1, present only with MPADD_SUB_EN: 1 selects A-B.
REQ-011 SHALL have port Result_o, output, N: registered result of the last completed operation.
REQ-012 SHALL have port Carry_o, output, 1: registered carry out of slice WORDS-1 of the last completed operation.
REQ-013 SHALL have port Valid_o, output, 1: one-cycle pulse marking Result_o/Carry_o updated.

Function
REQ-014 SHALL instantiate exactly one WIDTH-bit carry skip adder (cs_adder) and reuse it for every slice; no other adder on the datapath.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on Start_i=1, RUN->DONE after slice WORDS-1, DONE->IDLE unconditionally.
REQ-016 SHALL assert Ready_o only in IDLE; Start_i in RUN or DONE is ignored with no effect.
REQ-017 SHALL, on accept, latch A, B, Carry_i (and Sub_i) into internal registers, clear slice counter to 0, and not re-sample inputs until next accept.
REQ-018 SHALL, in RUN, process slice k = counter: adder inputs A[k*WIDTH+:WIDTH], B slice, carry register; sum stored into internal accumulator slice k; carry register <= adder carry out; counter increments.
REQ-019 SHALL use latched Carry_i as carry for slice 0 and the registered carry of slice k-1 for slice k.
REQ-020 SHALL spend exactly WORDS cycles in RUN; latency accept edge to Valid_o high = WORDS+1 cycles.
REQ-021 SHALL, on entering DONE, load Result_o from accumulator (including final slice) and Carry_o from final carry, and assert Valid_o for that single DONE cycle.
REQ-022 SHALL hold Result_o and Carry_o stable between completions; an ignored Start_i does not disturb them.
REQ-023 SHALL wrap modulo 2^N; overflow reported only via Carry_o.
REQ-024 SHALL allow back-to-back operations: Start_i high in the cycle after DONE is accepted (minimum 1 IDLE cycle between operations).

Reset
REQ-025 SHALL, with Reset_i=1 at a clock edge, force state IDLE, counter 0, carry register 0, Result_o 0, Carry_o 0, Valid_o 0, Ready_o 1 on the next cycle.
REQ-026 SHALL let reset take priority over Start_i and abort any RUN in progress with no Valid_o pulse and no change to Result_o beyond zeroing.

Configuration
REQ-027 SHALL compile subtraction support only when macro MPADD_SUB_EN is defined.
REQ-028 SHALL, with MPADD_SUB_EN and latched Sub_i=1, feed ~B slices to the adder and force slice-0 carry to 1 (Carry_i ignored); Carry_o=1 means no borrow.
REQ-029 SHALL, without MPADD_SUB_EN, omit port Sub_i and all inversion logic; behaviour is addition only.

Verification (WIDTH=32, WORDS=4)
REQ-030 SHALL cover: A=0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, B=1, Carry_i=0 -> Result_o=0x0000_0000_0000_0001_0000_0000_0000_0000, Carry_o=0, Valid_o exactly 5 cycles after accept.
REQ-031 SHALL cover: A=all ones, B=0, Carry_i=1 -> Result_o=0, Carry_o=1.
REQ-032 SHALL cover: Start_i held high for 10 cycles with new operands each cycle -> only first accepted, one Valid_o pulse, result from first operands, second accept on cycle after DONE.
REQ-033 SHALL cover: Reset_i pulsed 2 cycles after accept -> no Valid_o, Result_o=0, Carry_o=0, Ready_o=1 next cycle.
REQ-034 SHALL cover (MPADD_SUB_EN): A=5, B=3, Sub_i=1 -> Result_o=2, Carry_o=1; A=3, B=5 -> Result_o=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, Carry_o=0.
REQ-035 SHALL cover: 100 random A/B/Carry_i operations back-to-back -> {Carry_o,Result_o} equals A+B+Carry_i for every Valid_o.

Source files
------------

// File: rtl/mp_add_seq.sv
// Multi-precision adder: one WIDTH-bit carry-skip slice reused for WORDS cycles per operation.
// Define MPADD_SUB_EN to add the Sub_i port and A-B support (carry out of 1 means no borrow).

`timescale 1ns/1ps

module cs_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Ripple inside each block; a block whose bits all propagate passes its
    // incoming carry straight through, which is the skip path.
    always_comb begin : skip_chain
        logic c;
        logic blk_in;
        logic blk_p;
        logic p;
        // NOTE: blocking assignments here are intentional -- c is a running
        // value within one evaluation, not state.
        c      = cin;
        blk_in = cin;
        blk_p  = 1'b1;
        p      = 1'b0;
        sum    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            p      = a[i] ^ b[i];
            sum[i] = p ^ c;
            c      = (a[i] & b[i]) | (p & c);
            blk_p  = blk_p & p;
            if ((i % BLOCK) == (BLOCK - 1) || i == WIDTH - 1) begin
                c      = blk_p ? blk_in : c;
                blk_in = c;
                blk_p  = 1'b1;
            end
        end
        cout = c;
    end
endmodule

module mp_add_seq #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                     Clk_i,
    input  logic                     Reset_i,
    input  logic                     Start_i,
    output logic                     Ready_o,
    input  logic [WIDTH*WORDS-1:0]   Number1_i,
    input  logic [WIDTH*WORDS-1:0]   Number2_i,
    input  logic                     Carry_i,
`ifdef MPADD_SUB_EN
    input  logic                     Sub_i,
`endif
    output logic [WIDTH*WORDS-1:0]   Result_o,
    output logic                     Carry_o,
    output logic                     Valid_o
);
    localparam int N  = WIDTH * WORDS;
    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   acc_q;
`ifdef MPADD_SUB_EN
    logic           sub_q;
`endif

    logic [WIDTH-1:0] a_slice;
    logic [WIDTH-1:0] b_slice;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             sum_cout;
    logic [N-1:0]     acc_next;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (cnt_q == CW'(k)) begin
                a_slice = a_q[k*WIDTH +: WIDTH];
                b_slice = b_q[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MPADD_SUB_EN
    assign b_op = sub_q ? ~b_slice : b_slice;
`else
    assign b_op = b_slice;
`endif

    cs_adder #(.WIDTH(WIDTH)) u_slice_adder (
        .a    (a_slice),
        .b    (b_op),
        .cin  (carry_q),
        .sum  (sum),
        .cout (sum_cout)
    );

    // Accumulator with the current slice merged in, so the final slice can
    // reach Result_o on the same edge it is computed.
    always_comb begin
        acc_next = acc_q;
        for (int k = 0; k < WORDS; k++) begin
            if (cnt_q == CW'(k)) acc_next[k*WIDTH +: WIDTH] = sum;
        end
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            // NOTE: operand and accumulator registers are deliberately left
            // out of reset; they are always loaded before they are read.
            state    <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            Result_o <= '0;
            Carry_o  <= 1'b0;
            Valid_o  <= 1'b0;
            Ready_o  <= 1'b1;
        end else begin
            Valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    Ready_o <= 1'b1;
                    if (Start_i) begin
                        a_q     <= Number1_i;
                        b_q     <= Number2_i;
`ifdef MPADD_SUB_EN
                        sub_q   <= Sub_i;
                        carry_q <= Sub_i ? 1'b1 : Carry_i;
`else
                        carry_q <= Carry_i;
`endif
                        cnt_q   <= '0;
                        Ready_o <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= sum_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        Result_o <= acc_next;
                        Carry_o  <= sum_cout;
                        Valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    Ready_o <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    Ready_o <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mp_add_seq.sv
// Scoreboard bench for mp_add_seq (WIDTH=32, WORDS=4): directed vectors plus random back-to-back sums.

`timescale 1ns/1ps

module tb_mp_add_seq;
    localparam int WIDTH = 32;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;
    localparam int LAT   = WORDS + 1;

    logic         clk = 1'b0;
    logic         Reset_i, Start_i, Ready_o, Carry_i, Carry_o, Valid_o;
    logic         sub;
    logic [N-1:0] Number1_i, Number2_i, Result_o;

    always #5 clk = ~clk;

    mp_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .Clk_i     (clk),
        .Reset_i   (Reset_i),
        .Start_i   (Start_i),
        .Ready_o   (Ready_o),
        .Number1_i (Number1_i),
        .Number2_i (Number2_i),
        .Carry_i   (Carry_i),
`ifdef MPADD_SUB_EN
        .Sub_i     (sub),
`endif
        .Result_o  (Result_o),
        .Carry_o   (Carry_o),
        .Valid_o   (Valid_o)
    );

    typedef struct {
        logic [N:0] val;
        int         acc_cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Valid_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (Reset_i === 1'b0 && Valid_o !== 1'b0) begin
            if (sb.size() == 0) begin
                check("spurious_valid", Valid_o, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_sum"}, {Carry_o, Result_o}, e.val);
                check({e.name, "_latency"}, cyc - e.acc_cyc, LAT);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (Ready_o === 1'b1) return;
            @(posedge clk); #1;
        end
        check("ready_timeout", Ready_o, 1);
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic s, input logic [N:0] exp, input string name);
        exp_t e;
        wait_ready();
        Number1_i = a;
        Number2_i = b;
        Carry_i   = cin;
        sub       = s;
        Start_i   = 1'b1;
        e.val     = exp;
        e.acc_cyc = cyc;
        e.name    = name;
        sb.push_back(e);
        @(posedge clk); #1;
        Start_i = 1'b0;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        exp_t         e;

        Reset_i = 1'b1; Start_i = 1'b0; Carry_i = 1'b0; sub = 1'b0;
        Number1_i = '0; Number2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", Result_o, 0);
        check("rst_carry",  Carry_o,  0);
        check("rst_valid",  Valid_o,  0);
        check("rst_ready",  Ready_o,  1);
        Reset_i = 1'b0;
        @(posedge clk); #1;

        do_op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0,
              129'h0_0000_0000_0000_0001_0000_0000_0000_0000, "carry_chain");
        do_op({N{1'b1}}, '0, 1'b1, 1'b0, {1'b1, {N{1'b0}}}, "all_ones_cin");
        do_op(128'h8000_0000_0000_0000_0000_0000_0000_0000,
              128'h8000_0000_0000_0000_0000_0000_0000_0001, 1'b0, 1'b0,
              129'h1_0000_0000_0000_0000_0000_0000_0000_0001, "top_overflow");

        // Start_i held for 10 cycles: accepts in cycle 0 and again in the
        // first IDLE cycle after DONE; the rest are ignored.
        wait_ready();
        for (int i = 0; i < 10; i++) begin
            Number1_i = {32'(i), 64'h0, 32'hFFFF_FFFF};
            Number2_i = 128'h1;
            Carry_i   = 1'b0;
            sub       = 1'b0;
            Start_i   = 1'b1;
            if (i == 0) begin
                e.val = 129'h0_0000_0000_0000_0000_0000_0001_0000_0000;
                e.acc_cyc = cyc; e.name = "held_first"; sb.push_back(e);
            end
            if (i == LAT + 1) begin
                e.val = 129'h0_0000_0006_0000_0000_0000_0001_0000_0000;
                e.acc_cyc = cyc; e.name = "held_second"; sb.push_back(e);
            end
            @(posedge clk); #1;
            if (i == 2) check("held_ready_run", Ready_o, 0);
            if (i == 4) check("held_ready_done", Ready_o, 0);
            if (i == 8) check("held_result_stable", {Carry_o, Result_o},
                              129'h0_0000_0000_0000_0000_0000_0001_0000_0000);
        end
        Start_i = 1'b0;

        // Reset two cycles into a run: no pulse, outputs zeroed.
        do_op(128'h1234, 128'h1, 1'b0, 1'b0, 129'h1235, "aborted");
        @(posedge clk); #1;
        Reset_i = 1'b1;
        @(posedge clk); #1;
        Reset_i = 1'b0;
        void'(sb.pop_back());
        check("abort_result", Result_o, 0);
        check("abort_carry",  Carry_o,  0);
        check("abort_ready",  Ready_o,  1);
        check("abort_valid",  Valid_o,  0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        check("abort_quiet_result", Result_o, 0);

`ifdef MPADD_SUB_EN
        do_op(128'd5, 128'd3, 1'b0, 1'b1, {1'b1, 128'd2}, "sub_pos");
        do_op(128'd3, 128'd5, 1'b1, 1'b1,
              {1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE}, "sub_neg");
`endif

        for (int i = 0; i < 100; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            rc = 1'($urandom_range(1));
            if (i % 4 == 1) rb = ~ra;
            do_op(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + {{N{1'b0}}, rc}, "random");
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_pending", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
